// File: rtl/ledtoggle_multi_timer.sv
// Multi-channel interval timer on an Avalon-MM slave: NUM_CH down-counters with prescaler,
// one-shot/continuous modes, snapshot capture and a merged, maskable timeout interrupt.
module ledtoggle_multi_timer #(
  parameter int NUM_CH       = 4,
  parameter int CNT_WIDTH    = 32,
  parameter int RESET_PERIOD = 49999,
  localparam int CH_BITS     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [CH_BITS+2:0] address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  output logic               irq
);

  localparam int                   HI_W    = CNT_WIDTH - 16;
  localparam logic [CNT_WIDTH-1:0] RST_P   = CNT_WIDTH'(RESET_PERIOD);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    REG_STATUS, REG_CONTROL, REG_PERIOD_L, REG_PERIOD_H,
    REG_SNAP_L, REG_SNAP_H, REG_PENDING, REG_RSVD
  } reg_e;

  typedef struct packed {
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] period;
    logic [CNT_WIDTH-1:0] snap;
    logic [7:0]           pcnt;
    logic [7:0]           pre;
    logic                 ito;
    logic                 cont;
    logic                 to;
    logic                 run;
  } ch_t;

  localparam ch_t CH_RESET = '{count: RST_P, period: RST_P, default: '0};

  ch_t                ch_q [NUM_CH];
  ch_t                ch_d [NUM_CH];
  logic [NUM_CH-1:0]  tick;
  logic [NUM_CH-1:0]  timeout;
  logic [NUM_CH-1:0]  pending;
  logic [15:0]        readdata_d, readdata_q;
  logic               irq_q;

  logic               wr_en;
  logic [CH_BITS-1:0] acc_ch;
  reg_e               acc_reg;

  assign wr_en   = chipselect && !write_n;
  assign acc_ch  = address[CH_BITS+2:3];
  assign acc_reg = reg_e'(address[2:0]);

  // Event ordering inside each channel: tick first, then the bus write, then the timeout
  // sets TO last so a coincident status write cannot lose an interrupt.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      // NOTE: every signal driven here gets a default first so no path can infer a latch.
      ch_d[i]    = ch_q[i];
      tick[i]    = ch_q[i].run && (ch_q[i].pcnt == 8'd0);
      timeout[i] = 1'b0;

      if (ch_q[i].run) ch_d[i].pcnt = tick[i] ? ch_q[i].pre : ch_q[i].pcnt - 8'd1;

      if (tick[i]) begin
        if (ch_q[i].count == '0) begin
          ch_d[i].count = ch_q[i].period;
          timeout[i]    = 1'b1;
          if (!ch_q[i].cont) ch_d[i].run = 1'b0;
        end else begin
          ch_d[i].count = ch_q[i].count - CNT_ONE;
        end
      end

      if (wr_en && (acc_ch == CH_BITS'(i))) begin
        case (acc_reg)
          REG_STATUS: ch_d[i].to = 1'b0;
          REG_CONTROL: begin
            ch_d[i].ito  = writedata[0];
            ch_d[i].cont = writedata[1];
            ch_d[i].pre  = writedata[15:8];
            if (writedata[3]) ch_d[i].run = 1'b0;
            if (writedata[2]) begin
              ch_d[i].run  = 1'b1;
              ch_d[i].pcnt = 8'd0;
            end
          end
          REG_PERIOD_L, REG_PERIOD_H: begin
            if (acc_reg == REG_PERIOD_L) ch_d[i].period[15:0] = writedata;
            else                         ch_d[i].period[CNT_WIDTH-1:16] = writedata[HI_W-1:0];
            // A new period reloads the count and parks the channel; it overrides any tick.
            ch_d[i].count = ch_d[i].period;
            ch_d[i].run   = 1'b0;
            timeout[i]    = 1'b0;
          end
          REG_SNAP_L, REG_SNAP_H: ch_d[i].snap = ch_q[i].count;
          default: ;
        endcase
      end

      if (timeout[i]) ch_d[i].to = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) pending[i] = ch_q[i].to && ch_q[i].ito;
  end

  always_comb begin
    readdata_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (acc_ch == CH_BITS'(i)) begin
        case (acc_reg)
          REG_STATUS:   readdata_d = {14'd0, ch_q[i].run, ch_q[i].to};
          REG_CONTROL:  readdata_d = {ch_q[i].pre, 6'd0, ch_q[i].cont, ch_q[i].ito};
          REG_PERIOD_L: readdata_d = ch_q[i].period[15:0];
          REG_PERIOD_H: readdata_d = 16'(ch_q[i].period[CNT_WIDTH-1:16]);
          REG_SNAP_L:   readdata_d = ch_q[i].snap[15:0];
          REG_SNAP_H:   readdata_d = 16'(ch_q[i].snap[CNT_WIDTH-1:16]);
          REG_PENDING:  readdata_d = 16'(pending);
          default:      readdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the channel array is real control state, so every entry is reset, not left to software.
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= CH_RESET;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all state updates on the same edge order-independent.
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= ch_d[i];
      readdata_q <= readdata_d;
      irq_q      <= |pending;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
